main_memory_model: RTL and testbench
====================================

Name: main_memory_model

Overview:
- Backing-store model of main memory, directly downstream of the L2 cache on its memory interface.
- Accepts full-block read and write requests and holds each for a configurable latency.
- Returns one block per request with a single-cycle mem_ready pulse.
- Tracks the last-accessed block as an "open row": an access to that block completes with reduced latency and asserts mem_hit alongside mem_ready, which L2 consumes as its fast-path indication.

Parameters:
- DATA_WIDTH, 32, bits per word
- ADDR_WIDTH, 32, address width
- BLOCK_SIZE, 16, words per block; must equal the L2 BLOCK_SIZE
- MEM_BLOCKS, 256, number of blocks stored; power of two
- READ_LATENCY, 8, cycles from request acceptance to mem_ready on a row miss; must be >= 2
- HIT_LATENCY, 2, cycles from request acceptance to mem_ready on a row hit; 1 <= HIT_LATENCY < READ_LATENCY

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mem_addr  in  ADDR_WIDTH  request address; the low clog2(BLOCK_SIZE) bits are ignored
- mem_wdata  in  BLOCK_SIZE*DATA_WIDTH  write block (packed [BLOCK_SIZE-1:0][DATA_WIDTH-1:0])
- mem_rdata  out  BLOCK_SIZE*DATA_WIDTH  read block, same packing
- mem_read  in  1  read request, level, held until mem_ready
- mem_write  in  1  write request, level, held until mem_ready
- mem_ready  out  1  one-cycle completion pulse
- mem_hit  out  1  completed access was an open-row hit; valid only while mem_ready=1
- busy  out  1  a transaction is in flight

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Address decode:
  - OFF = clog2(BLOCK_SIZE); IDX = clog2(MEM_BLOCKS).
  - Block index = mem_addr[OFF+IDX-1:OFF]; upper address bits are ignored (aliasing).
- Reset values (all registered):
  - mem_ready=0, mem_hit=0, busy=0, mem_rdata=0, state=IDLE, row_valid=0, cnt=0.
  - Array contents are not affected by reset.
- States: IDLE, BUSY, RESPOND.
- IDLE:
  - On an edge with mem_read|mem_write=1 (call it E0), capture block index, op, and mem_wdata.
  - row_hit = row_valid && (index == row_index).
  - L = row_hit ? HIT_LATENCY : READ_LATENCY.
  - If L==1, go to RESPOND; otherwise set cnt=L-2 and go to BUSY.
  - If both mem_read and mem_write are asserted, read wins; the write is ignored for that transaction.
- BUSY:
  - If cnt==0, go to RESPOND on the next edge; otherwise cnt decrements.
  - Request inputs are ignored.
  - Deasserting the request mid-transaction does not cancel it; the transaction completes.
- Commit (edge entering RESPOND):
  - Write: array[idx] <= captured wdata.
  - Read: mem_rdata <= array[idx].
  - row_index <= idx; row_valid <= 1.
- RESPOND:
  - Lasts exactly one cycle; mem_ready=1 and mem_hit=captured row_hit.
  - On a write completion, mem_rdata holds its previous value.
  - Always returns to IDLE.
- Timing: mem_ready is high in the cycle beginning at edge E0+L.
- Back-to-back requests:
  - A request still asserted in IDLE after RESPOND starts a new transaction.
  - The earliest re-acceptance is edge E0+L+1.
- busy = 1 in BUSY and RESPOND.
- Read-after-write to the same block returns the written data; the write commits before any later read is accepted.
- Reset mid-transaction:
  - Aborts the transaction; no array write occurs if the commit edge has not yet been reached.
  - row_valid clears; no mem_ready is produced.

Decomposition:
- Package main_mem_pkg:
  - state enum (IDLE, BUSY, RESPOND)
  - localparams OFF, IDX, CNT_W = clog2(READ_LATENCY)
  - block typedef [BLOCK_SIZE-1:0][DATA_WIDTH-1:0]
- Sub-module main_mem_array:
  - MEM_BLOCKS x block storage.
  - Synchronous write and synchronous read on a shared port, with a write-enable/read-enable strobe from the FSM.

Test Plan:
1. Write then miss read, READ_LATENCY=8, HIT_LATENCY=2:
   - Reset; write block 0x00000100 with word w = 0xA000_0000+w; mem_ready at E0+8 with mem_hit=0.
   - Read 0x00000100 -> mem_ready at E0+2, mem_hit=1, rdata word 5 = 0xA0000005.
2. Row miss: read 0x00000200 after test 1 -> mem_ready at E0+8, mem_hit=0; a following read of 0x00000100 is again a miss (8 cycles).
3. Ignored offset bits: read 0x0000010C -> same data as 0x00000100; address bits above OFF+IDX alias (0x00010100 returns the same block).
4. Simultaneous request: mem_read=1 and mem_write=1 with wdata=all 0xFFFFFFFF -> treated as a read; the array is unchanged and a later read returns the prior contents.
5. Request dropped mid-transaction: mem_read drops at E0+3 -> mem_ready still pulses at E0+8 for one cycle; no second transaction starts.
6. Reset mid-write: rst at E0+4 of a write to 0x00000300 -> no mem_ready; a later read of 0x00000300 returns the pre-write contents with mem_hit=0.

Source files
------------

// File: rtl/main_mem_pkg.sv
// Shared types and default geometry for the main memory backing-store model.
package main_mem_pkg;
  localparam int MM_DATA_WIDTH   = 32;
  localparam int MM_ADDR_WIDTH   = 32;
  localparam int MM_BLOCK_SIZE   = 16;
  localparam int MM_MEM_BLOCKS   = 256;
  localparam int MM_READ_LATENCY = 8;
  localparam int MM_HIT_LATENCY  = 2;

  localparam int OFF   = $clog2(MM_BLOCK_SIZE);
  localparam int IDX   = $clog2(MM_MEM_BLOCKS);
  localparam int CNT_W = $clog2(MM_READ_LATENCY);

  typedef logic [MM_BLOCK_SIZE-1:0][MM_DATA_WIDTH-1:0] block_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESPOND = 2'd2
  } state_t;
endpackage

// File: rtl/main_memory_model_if.sv
// L2-to-memory block interface. mem_read/mem_write are level requests held until mem_ready.
interface main_memory_model_if
  import main_mem_pkg::*;
#(
  parameter int DATA_WIDTH = MM_DATA_WIDTH,
  parameter int ADDR_WIDTH = MM_ADDR_WIDTH,
  parameter int BLOCK_SIZE = MM_BLOCK_SIZE
);
  // Handshake: a request (read or write level) is accepted on the first edge it is seen
  // while the memory is idle; mem_ready is a one-cycle completion pulse with mem_hit and
  // mem_rdata valid alongside it. The requester drops its request after mem_ready.
  logic [ADDR_WIDTH-1:0]                  mem_addr;
  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0]  mem_wdata;
  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0]  mem_rdata;
  logic                                   mem_read;
  logic                                   mem_write;
  logic                                   mem_ready;
  logic                                   mem_hit;
  logic                                   busy;

  modport master (
    output mem_addr, mem_wdata, mem_read, mem_write,
    input  mem_rdata, mem_ready, mem_hit, busy
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_read, mem_write,
    output mem_rdata, mem_ready, mem_hit, busy
  );
endinterface

// File: rtl/main_mem_array.sv
// Block storage with one shared synchronous port; write has priority over read.
module main_mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int BLOCK_SIZE = 16,
  parameter int MEM_BLOCKS = 256,
  localparam int IW = $clog2(MEM_BLOCKS)
) (
  input  logic                                  clk,
  input  logic                                  we,
  input  logic                                  re,
  input  logic [IW-1:0]                         idx,
  input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] wdata,
  output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] rdata
);
  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_q [MEM_BLOCKS];
  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] rdata_q;
  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re && !we) rdata_d = mem_q[idx];
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[idx] <= wdata;
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/main_memory_model.sv
// Main memory model: fixed-latency block reads/writes with a single open row giving a fast path.
module main_memory_model
  import main_mem_pkg::*;
#(
  parameter int DATA_WIDTH   = MM_DATA_WIDTH,
  parameter int ADDR_WIDTH   = MM_ADDR_WIDTH,
  parameter int BLOCK_SIZE   = MM_BLOCK_SIZE,
  parameter int MEM_BLOCKS   = MM_MEM_BLOCKS,
  parameter int READ_LATENCY = MM_READ_LATENCY,
  parameter int HIT_LATENCY  = MM_HIT_LATENCY
) (
  input  logic                clk,
  input  logic                rst,
  main_memory_model_if.slave  bus,
  output state_t              dbg_state
);
  localparam int BLK_OFF  = $clog2(BLOCK_SIZE);
  localparam int BLK_IDX  = $clog2(MEM_BLOCKS);
  localparam int CNT_BITS = $clog2(READ_LATENCY);

  typedef logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] blk_t;

  state_t                state_q, state_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic [BLK_IDX-1:0]    idx_q, idx_d;
  logic [BLK_IDX-1:0]    row_idx_q, row_idx_d;
  logic                  row_valid_q, row_valid_d;
  logic                  is_write_q, is_write_d;
  logic                  hit_q, hit_d;
  blk_t                  wdata_q, wdata_d;
  logic                  ready_q, ready_d;
  logic                  hit_out_q, hit_out_d;
  logic                  busy_q, busy_d;
  blk_t                  rdata_q, rdata_d;

  logic [BLK_IDX-1:0]    req_idx;
  logic                  req_hit;
  logic                  req_one;
  logic [CNT_BITS-1:0]   req_cnt;
  logic                  commit;
  logic                  commit_wr;
  logic [BLK_IDX-1:0]    arr_idx;
  blk_t                  arr_wdata;
  blk_t                  arr_rdata;
  logic                  arr_we, arr_re;
  logic                  unused_addr_bits;

  assign req_idx = bus.mem_addr[BLK_OFF+BLK_IDX-1:BLK_OFF];
  assign req_hit = row_valid_q && (req_idx == row_idx_q);
  assign req_one = req_hit && (HIT_LATENCY == 1);
  assign req_cnt = req_hit ? CNT_BITS'(HIT_LATENCY - 2) : CNT_BITS'(READ_LATENCY - 2);
  assign unused_addr_bits = ^{bus.mem_addr};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    row_idx_d   = row_idx_q;
    row_valid_d = row_valid_q;
    is_write_d  = is_write_q;
    hit_d       = hit_q;
    wdata_d     = wdata_q;
    commit      = 1'b0;
    commit_wr   = is_write_q;
    arr_idx     = idx_q;
    arr_wdata   = wdata_q;
    case (state_q)
      IDLE: begin
        if (bus.mem_read || bus.mem_write) begin
          idx_d      = req_idx;
          is_write_d = !bus.mem_read;
          wdata_d    = bus.mem_wdata;
          hit_d      = req_hit;
          if (req_one) begin
            // Single-cycle hit commits on the acceptance edge straight from the inputs.
            state_d   = RESPOND;
            commit    = 1'b1;
            commit_wr = !bus.mem_read;
            arr_idx   = req_idx;
            arr_wdata = bus.mem_wdata;
          end else begin
            state_d = BUSY;
            cnt_d   = req_cnt;
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = RESPOND;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (commit) begin
      row_idx_d   = arr_idx;
      row_valid_d = 1'b1;
    end
  end

  // The array is not reset, so a reset on the commit edge must suppress the strobe itself.
  assign arr_we = commit && commit_wr && !rst;
  assign arr_re = commit && !commit_wr && !rst;

  // Array output is valid during RESPOND; outputs are registered off that cycle.
  always_comb begin
    ready_d   = (state_q == RESPOND);
    hit_out_d = (state_q == RESPOND) && hit_q;
    busy_d    = (state_d != IDLE);
    rdata_d   = rdata_q;
    if (state_q == RESPOND && !is_write_q) rdata_d = arr_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      row_idx_q   <= '0;
      row_valid_q <= 1'b0;
      is_write_q  <= 1'b0;
      hit_q       <= 1'b0;
      wdata_q     <= '0;
      ready_q     <= 1'b0;
      hit_out_q   <= 1'b0;
      busy_q      <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      row_idx_q   <= row_idx_d;
      row_valid_q <= row_valid_d;
      is_write_q  <= is_write_d;
      hit_q       <= hit_d;
      wdata_q     <= wdata_d;
      ready_q     <= ready_d;
      hit_out_q   <= hit_out_d;
      busy_q      <= busy_d;
      rdata_q     <= rdata_d;
    end
  end

  main_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .BLOCK_SIZE (BLOCK_SIZE),
    .MEM_BLOCKS (MEM_BLOCKS)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (arr_re),
    .idx   (arr_idx),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  assign bus.mem_ready = ready_q;
  assign bus.mem_hit   = hit_out_q;
  assign bus.busy      = busy_q;
  assign bus.mem_rdata = rdata_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_main_memory_model.sv
// Directed bench for main_memory_model: latency, open-row hits, aliasing, abort and reset cases.
module tb_main_memory_model;
  import main_mem_pkg::*;

  logic   clk;
  logic   rst;
  state_t dbg_state;
  int     n_cmp;
  int     n_fail;

  main_memory_model_if bus ();

  main_memory_model dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic block_t pat(input logic [31:0] base);
    block_t p;
    for (int w = 0; w < MM_BLOCK_SIZE; w++) p[w] = base + 32'(w);
    return p;
  endfunction

  // Drives one request, waits up to 40 edges for mem_ready, then drops the request.
  task automatic do_req(input logic [31:0] addr, input logic rd, input logic wr,
                        input block_t wd, output int lat, output logic hit,
                        output block_t rdat, output logic busy1, output logic ready_after);
    @(negedge clk);
    bus.mem_addr  = addr;
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.mem_wdata = wd;
    @(posedge clk);
    lat = 0; hit = 1'b0; rdat = '0; busy1 = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == 1) busy1 = bus.busy;
      if (bus.mem_ready) begin
        lat = n; hit = bus.mem_hit; rdat = bus.mem_rdata;
        break;
      end
    end
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    @(posedge clk); #1;
    ready_after = bus.mem_ready;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_cmp++;
    if (bus.mem_ready !== 1'b0 || bus.mem_hit !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: ready=%b hit=%b busy=%b, want 0 0 0",
                         bus.mem_ready, bus.mem_hit, bus.busy);
    end
    n_cmp++;
    if (bus.mem_rdata !== '0 || dbg_state !== IDLE) begin
      n_fail++; $display("FAIL reset_rdata_state: rdata[0]=%h state=%0d, want 0 IDLE",
                         bus.mem_rdata[0], dbg_state);
    end
  endtask

  task automatic test_write_then_hit();
    int lat; logic hit, b1, ra; block_t rd;
    do_req(32'h100, 1'b0, 1'b1, pat(32'hA000_0000), lat, hit, rd, b1, ra);
    n_cmp++;
    if (lat !== 8 || hit !== 1'b0) begin
      n_fail++; $display("FAIL write_miss: lat=%0d hit=%b, want 8 0", lat, hit);
    end
    n_cmp++;
    if (b1 !== 1'b1 || ra !== 1'b0) begin
      n_fail++; $display("FAIL busy_pulse: busy=%b ready_next=%b, want 1 0", b1, ra);
    end
    do_req(32'h100, 1'b1, 1'b0, '0, lat, hit, rd, b1, ra);
    n_cmp++;
    if (lat !== 2 || hit !== 1'b1 || rd[5] !== 32'hA000_0005) begin
      n_fail++; $display("FAIL read_hit: lat=%0d hit=%b w5=%h, want 2 1 a0000005", lat, hit, rd[5]);
    end
    n_cmp++;
    if (rd !== pat(32'hA000_0000)) begin
      n_fail++; $display("FAIL read_hit_block: w0=%h w15=%h, want a0000000 a000000f", rd[0], rd[15]);
    end
  endtask

  task automatic test_row_miss();
    int lat; logic hit, b1, ra; block_t rd;
    do_req(32'h200, 1'b1, 1'b0, '0, lat, hit, rd, b1, ra);
    n_cmp++;
    if (lat !== 8 || hit !== 1'b0) begin
      n_fail++; $display("FAIL row_miss: lat=%0d hit=%b, want 8 0", lat, hit);
    end
    do_req(32'h100, 1'b1, 1'b0, '0, lat, hit, rd, b1, ra);
    n_cmp++;
    if (lat !== 8 || hit !== 1'b0 || rd !== pat(32'hA000_0000)) begin
      n_fail++; $display("FAIL row_reopen: lat=%0d hit=%b w0=%h, want 8 0 a0000000", lat, hit, rd[0]);
    end
  endtask

  task automatic test_alias();
    int lat; logic hit, b1, ra; block_t rd;
    do_req(32'h10C, 1'b1, 1'b0, '0, lat, hit, rd, b1, ra);
    n_cmp++;
    if (lat !== 2 || hit !== 1'b1 || rd !== pat(32'hA000_0000)) begin
      n_fail++; $display("FAIL offset_ignored: lat=%0d hit=%b w0=%h, want 2 1 a0000000", lat, hit, rd[0]);
    end
    do_req(32'h0001_0100, 1'b1, 1'b0, '0, lat, hit, rd, b1, ra);
    n_cmp++;
    if (lat !== 2 || hit !== 1'b1 || rd !== pat(32'hA000_0000)) begin
      n_fail++; $display("FAIL upper_alias: lat=%0d hit=%b w0=%h, want 2 1 a0000000", lat, hit, rd[0]);
    end
  endtask

  task automatic test_read_wins();
    int lat; logic hit, b1, ra; block_t rd;
    do_req(32'h100, 1'b1, 1'b1, {MM_BLOCK_SIZE{32'hFFFF_FFFF}}, lat, hit, rd, b1, ra);
    n_cmp++;
    if (lat !== 2 || rd !== pat(32'hA000_0000)) begin
      n_fail++; $display("FAIL both_req_read: lat=%0d w0=%h, want 2 a0000000", lat, rd[0]);
    end
    do_req(32'h100, 1'b1, 1'b0, '0, lat, hit, rd, b1, ra);
    n_cmp++;
    if (rd !== pat(32'hA000_0000)) begin
      n_fail++; $display("FAIL both_req_unchanged: w0=%h w9=%h, want a0000000 a0000009", rd[0], rd[9]);
    end
  endtask

  task automatic test_drop_mid();
    logic [15:0] seen;
    seen = '0;
    @(negedge clk);
    bus.mem_addr = 32'h200; bus.mem_read = 1'b1; bus.mem_write = 1'b0;
    @(posedge clk);
    for (int n = 1; n <= 16; n++) begin
      @(posedge clk); #1;
      if (n == 3) bus.mem_read = 1'b0;
      seen[n-1] = bus.mem_ready;
    end
    n_cmp++;
    if (seen !== 16'h0080) begin
      n_fail++; $display("FAIL drop_mid: ready_pattern=%h, want 0080", seen);
    end
    n_cmp++;
    if (bus.busy !== 1'b0 || dbg_state !== IDLE) begin
      n_fail++; $display("FAIL drop_idle: busy=%b state=%0d, want 0 IDLE", bus.busy, dbg_state);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seen;
    seen = '0;
    @(negedge clk);
    bus.mem_addr = 32'h200; bus.mem_read = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      seen[n-1] = bus.mem_ready;
      if (n == 5) bus.mem_read = 1'b0;
    end
    n_cmp++;
    if (seen !== 8'b0001_0010) begin
      n_fail++; $display("FAIL back_to_back: ready_pattern=%b, want 00010010", seen);
    end
  endtask

  task automatic test_reset_mid_write();
    int lat; logic hit, b1, ra; block_t rd;
    logic got_ready;
    do_req(32'h300, 1'b0, 1'b1, pat(32'hB000_0000), lat, hit, rd, b1, ra);
    do_req(32'h100, 1'b1, 1'b0, '0, lat, hit, rd, b1, ra);
    n_cmp++;
    if (lat !== 8 || rd !== pat(32'hA000_0000)) begin
      n_fail++; $display("FAIL pre_abort_read: lat=%0d w0=%h, want 8 a0000000", lat, rd[0]);
    end
    got_ready = 1'b0;
    @(negedge clk);
    bus.mem_addr = 32'h300; bus.mem_write = 1'b1; bus.mem_wdata = pat(32'hC000_0000);
    @(posedge clk);
    for (int n = 1; n <= 14; n++) begin
      @(posedge clk); #1;
      if (n == 3) begin rst = 1'b1; bus.mem_write = 1'b0; end
      if (n == 4) rst = 1'b0;
      if (bus.mem_ready) got_ready = 1'b1;
    end
    n_cmp++;
    if (got_ready !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_no_ready: ready_seen=%b busy=%b, want 0 0", got_ready, bus.busy);
    end
    do_req(32'h300, 1'b1, 1'b0, '0, lat, hit, rd, b1, ra);
    n_cmp++;
    if (lat !== 8 || hit !== 1'b0 || rd !== pat(32'hB000_0000)) begin
      n_fail++; $display("FAIL abort_contents: lat=%0d hit=%b w0=%h, want 8 0 b0000000", lat, hit, rd[0]);
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst = 1'b1;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;
    test_reset();
    test_write_then_hit();
    test_row_miss();
    test_alias();
    test_read_wins();
    test_drop_mid();
    test_back_to_back();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
